// File: rtl/npc_unit.sv
// Fetch-side next-PC controller: holds the F-stage PC and applies jump, branch and
// exception redirects. A redirect that arrives during a stall is buffered until fetch resumes.
module npc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180,
    parameter logic [31:0] IM_LO    = 32'h0000_3000,
    parameter logic [31:0] IM_HI    = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        exc_valid,
    input  logic        eret_valid,
    input  logic [31:0] epc,
    input  logic        jr_valid,
    input  logic [31:0] jr_target,
    input  logic        j_valid,
    input  logic [25:0] j_index,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [15:0] br_offset,
    output logic [31:0] pc_f,
    output logic        redirect,
    output logic        pending,
    output logic        adel_f
);

    typedef enum logic {S_RUN = 1'b0, S_PEND = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_pend_tgt;
    logic        r_redirect;
    logic        r_adel;

    logic [31:0] w_pc_next;
    logic [31:0] w_pend_tgt_next;
    logic        w_redirect_next;
    logic        w_adel_next;

    logic        w_exc_any;
    logic [31:0] w_exc_tgt;
    logic        w_d_valid;
    logic [31:0] w_d_tgt;
    logic [31:0] w_j_tgt;
    logic [31:0] w_br_tgt;

    // r_pc is already the delay-slot PC, so both J and branch targets are based on it.
    assign w_j_tgt   = {r_pc[31:28], j_index, 2'b00};
    assign w_br_tgt  = r_pc + {{14{br_offset[15]}}, br_offset, 2'b00};
    assign w_exc_any = exc_valid | eret_valid;
    assign w_exc_tgt = exc_valid ? EXC_PC : epc;
    assign w_d_valid = jr_valid | j_valid | (br_valid & br_taken);
    assign w_d_tgt   = jr_valid ? jr_target : (j_valid ? w_j_tgt : w_br_tgt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_exc_any) begin
            w_state_next = S_RUN;
        end else begin
            case (r_state)
                S_RUN:   if (stall && w_d_valid) w_state_next = S_PEND;
                S_PEND:  if (!stall) w_state_next = S_RUN;
                default: w_state_next = S_RUN;
            endcase
        end
    end

    always_comb begin
        w_pc_next       = r_pc;
        w_pend_tgt_next = r_pend_tgt;
        w_redirect_next = 1'b0;
        if (w_exc_any) begin
            // Exceptions bypass the stall and drop any buffered target.
            w_pc_next       = w_exc_tgt;
            w_pend_tgt_next = 32'h0;
            w_redirect_next = 1'b1;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (!stall && w_d_valid) begin
                        w_pc_next       = w_d_tgt;
                        w_redirect_next = 1'b1;
                    end else if (!stall) begin
                        w_pc_next = r_pc + 32'd4;
                    end else if (w_d_valid) begin
                        w_pend_tgt_next = w_d_tgt;
                    end
                end
                S_PEND: begin
                    if (!stall) begin
                        w_pc_next       = r_pend_tgt;
                        w_redirect_next = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_adel_next = (w_pc_next[1:0] != 2'b00) || (w_pc_next < IM_LO) || (w_pc_next > IM_HI);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc       <= RESET_PC;
            r_pend_tgt <= 32'h0;
            r_redirect <= 1'b0;
            r_adel     <= 1'b0;
        end else begin
            r_pc       <= w_pc_next;
            r_pend_tgt <= w_pend_tgt_next;
            r_redirect <= w_redirect_next;
            r_adel     <= w_adel_next;
        end
    end

    assign pc_f     = r_pc;
    assign redirect = r_redirect;
    assign pending  = (r_state == S_PEND);
    assign adel_f   = r_adel;

endmodule
